// File: rtl/cv32e40p_glitch_pkg.sv
// Shared types and default parameters for the PDL clock-glitch alarm controller.
// Imported by the interface, the window filter and the top.
package cv32e40p_glitch_pkg;

  typedef enum logic [1:0] {
    ARMING  = 2'd0,
    MONITOR = 2'd1,
    FAULT   = 2'd2
  } glitch_state_e;

  localparam int unsigned DEF_NUM_SENSORS = 2;
  localparam int unsigned DEF_ARM_CYCLES  = 8;
  localparam int unsigned DEF_WINDOW      = 16;
  localparam int unsigned DEF_THRESHOLD   = 2;
  localparam int unsigned DEF_CNT_W       = 16;

  // Bits needed to hold the values 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cv32e40p_glitch_alarm_ctrl_if.sv
// Sensor-side / core-side signal bundle of the glitch alarm controller.
// The master drives alarms, enables and clear; the slave is the controller.
interface cv32e40p_glitch_alarm_ctrl_if
  import cv32e40p_glitch_pkg::*;
#(
  parameter int unsigned NUM_SENSORS = DEF_NUM_SENSORS,
  parameter int unsigned CNT_W       = DEF_CNT_W
);
  logic [NUM_SENSORS-1:0] alarm_i;
  logic [NUM_SENSORS-1:0] sensor_en_i;
  logic                   clear_i;
  logic                   armed_o;
  logic                   fault_o;
  logic                   halt_o;
  logic                   fault_irq_o;
  logic [CNT_W-1:0]       hit_cnt_o;
  logic [NUM_SENSORS-1:0] first_src_o;

  modport master (
    output alarm_i, sensor_en_i, clear_i,
    input  armed_o, fault_o, halt_o, fault_irq_o, hit_cnt_o, first_src_o
  );

  modport slave (
    input  alarm_i, sensor_en_i, clear_i,
    output armed_o, fault_o, halt_o, fault_irq_o, hit_cnt_o, first_src_o
  );
endinterface

// File: rtl/cv32e40p_glitch_window.sv
// Hit-count-within-window filter: the first hit opens a WINDOW-cycle window,
// threshold_hit_o flags the hit that brings the in-window count to THRESHOLD.
module cv32e40p_glitch_window
  import cv32e40p_glitch_pkg::*;
#(
  parameter int unsigned WINDOW    = DEF_WINDOW,
  parameter int unsigned THRESHOLD = DEF_THRESHOLD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush_i,
  input  logic hit_i,
  output logic threshold_hit_o
);

  localparam int unsigned LEFT_W = cnt_width(WINDOW);
  localparam int unsigned HITS_W = cnt_width(THRESHOLD);
  // left_q holds the cycles remaining after the current one; the opening
  // cycle itself is already one of the WINDOW cycles.
  localparam int unsigned OPEN_LEFT  = (WINDOW > 1) ? WINDOW - 2 : 0;
  localparam bit          KEEPS_OPEN = (WINDOW > 1);

  logic              open_q, open_d;
  logic [LEFT_W-1:0] left_q, left_d;
  logic [HITS_W-1:0] hits_q, hits_d;
  logic [HITS_W:0]   hits_inc;

  always_comb begin
    open_d   = open_q;
    left_d   = left_q;
    hits_d   = hits_q;
    hits_inc = open_q ? ({1'b0, hits_q} + (HITS_W+1)'(1)) : (HITS_W+1)'(1);

    if (open_q) begin
      if (hit_i) begin
        hits_d = hits_inc[HITS_W-1:0];
      end
      if (left_q == '0) begin
        open_d = 1'b0;
        hits_d = '0;
      end else begin
        left_d = left_q - LEFT_W'(1);
      end
    end else if (hit_i && KEEPS_OPEN) begin
      open_d = 1'b1;
      left_d = LEFT_W'(OPEN_LEFT);
      hits_d = HITS_W'(1);
    end

    if (flush_i) begin
      open_d = 1'b0;
      left_d = '0;
      hits_d = '0;
    end

    threshold_hit_o = hit_i && (hits_inc >= (HITS_W+1)'(THRESHOLD));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      open_q <= 1'b0;
      left_q <= '0;
      hits_q <= '0;
    end else begin
      open_q <= open_d;
      left_q <= left_d;
      hits_q <= hits_d;
    end
  end

endmodule

// File: rtl/cv32e40p_glitch_alarm_ctrl.sv
// Qualifies raw PDL glitch-sensor alarms into a sticky core fault with halt,
// a one-cycle interrupt, a lifetime hit counter and first-source capture.
module cv32e40p_glitch_alarm_ctrl
  import cv32e40p_glitch_pkg::*;
#(
  parameter int unsigned NUM_SENSORS = DEF_NUM_SENSORS,
  parameter int unsigned ARM_CYCLES  = DEF_ARM_CYCLES,
  parameter int unsigned WINDOW      = DEF_WINDOW,
  parameter int unsigned THRESHOLD   = DEF_THRESHOLD,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  cv32e40p_glitch_alarm_ctrl_if.slave bus
);

  localparam int unsigned ARM_W = cnt_width(ARM_CYCLES - 1);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_CYCLES - 1);

  glitch_state_e          state_q, state_d;
  logic [ARM_W-1:0]       arm_cnt_q, arm_cnt_d;
  logic [NUM_SENSORS-1:0] alarm_q;
  logic [CNT_W-1:0]       hit_cnt_q, hit_cnt_d;
  logic [NUM_SENSORS-1:0] first_src_q, first_src_d;
  logic                   armed_q, armed_d;
  logic                   fault_q, fault_d;
  logic                   irq_q, irq_d;

  logic [NUM_SENSORS-1:0] hit_vec;
  logic                   hit;
  logic                   win_hit;
  logic                   win_flush;
  logic                   threshold_hit;

  // Enables gate the registered sample combinationally, so mask changes
  // take effect immediately without disturbing an open window.
  assign hit_vec   = alarm_q & bus.sensor_en_i;
  assign hit       = |hit_vec;
  assign win_hit   = hit && (state_q == MONITOR);
  assign win_flush = (state_q != MONITOR);

  cv32e40p_glitch_window #(
    .WINDOW    (WINDOW),
    .THRESHOLD (THRESHOLD)
  ) u_window (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush_i         (win_flush),
    .hit_i           (win_hit),
    .threshold_hit_o (threshold_hit)
  );

  always_comb begin
    state_d     = state_q;
    arm_cnt_d   = '0;
    first_src_d = first_src_q;
    hit_cnt_d   = hit_cnt_q;

    case (state_q)
      ARMING: begin
        arm_cnt_d = arm_cnt_q + ARM_W'(1);
        if (arm_cnt_q == ARM_LAST) begin
          state_d   = MONITOR;
          arm_cnt_d = '0;
        end
      end
      MONITOR: begin
        if (threshold_hit) begin
          state_d     = FAULT;
          first_src_d = hit_vec;
        end
      end
      FAULT: begin
        if (bus.clear_i) begin
          state_d = ARMING;
        end
      end
      default: state_d = ARMING;
    endcase

    if (hit && (state_q != ARMING) && (hit_cnt_q != '1)) begin
      hit_cnt_d = hit_cnt_q + CNT_W'(1);
    end

    armed_d = (state_d == MONITOR);
    fault_d = (state_d == FAULT);
    irq_d   = (state_d == FAULT) && (state_q != FAULT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ARMING;
      arm_cnt_q   <= '0;
      alarm_q     <= '0;
      hit_cnt_q   <= '0;
      first_src_q <= '0;
      armed_q     <= 1'b0;
      fault_q     <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      arm_cnt_q   <= arm_cnt_d;
      alarm_q     <= bus.alarm_i;
      hit_cnt_q   <= hit_cnt_d;
      first_src_q <= first_src_d;
      armed_q     <= armed_d;
      fault_q     <= fault_d;
      irq_q       <= irq_d;
    end
  end

  assign bus.armed_o     = armed_q;
  assign bus.fault_o     = fault_q;
  assign bus.halt_o      = fault_q;
  assign bus.fault_irq_o = irq_q;
  assign bus.hit_cnt_o   = hit_cnt_q;
  assign bus.first_src_o = first_src_q;

endmodule

// File: tb/tb_cv32e40p_glitch_alarm_ctrl.sv
// Scoreboard bench: a time-based reference model predicts every cycle's outputs
// for a 16-bit and a 4-bit counter instance driven by identical stimulus.
module tb_cv32e40p_glitch_alarm_ctrl;

  localparam int unsigned NS  = 2;
  localparam int unsigned ARM = 8;
  localparam int unsigned WIN = 16;
  localparam int unsigned THR = 2;

  localparam int M_ARM   = 0;
  localparam int M_MON   = 1;
  localparam int M_FAULT = 2;

  typedef struct {
    logic        armed;
    logic        fault;
    logic        irq;
    int unsigned cnt_a;
    int unsigned cnt_b;
    logic [1:0]  src;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NS-1:0] alarm;
  logic [NS-1:0] en;
  logic          clr;

  cv32e40p_glitch_alarm_ctrl_if #(.NUM_SENSORS(NS), .CNT_W(16)) ifa ();
  cv32e40p_glitch_alarm_ctrl_if #(.NUM_SENSORS(NS), .CNT_W(4))  ifb ();

  assign ifa.alarm_i     = alarm;
  assign ifa.sensor_en_i = en;
  assign ifa.clear_i     = clr;
  assign ifb.alarm_i     = alarm;
  assign ifb.sensor_en_i = en;
  assign ifb.clear_i     = clr;

  cv32e40p_glitch_alarm_ctrl #(
    .NUM_SENSORS(NS), .ARM_CYCLES(ARM), .WINDOW(WIN), .THRESHOLD(THR), .CNT_W(16)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  cv32e40p_glitch_alarm_ctrl #(
    .NUM_SENSORS(NS), .ARM_CYCLES(ARM), .WINDOW(WIN), .THRESHOLD(THR), .CNT_W(4)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  always #5 clk = ~clk;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_miss = 0;
  bit   active = 1'b0;

  // Reference model: mode plus timestamps of arming start and window opening.
  int          mode = M_ARM;
  int unsigned t = 0;
  int unsigned arm_elapsed = 0;
  bit          win_valid = 1'b0;
  int unsigned win_start = 0;
  int unsigned win_hits = 0;
  int unsigned hit_total = 0;
  logic [1:0]  m_src = '0;
  logic        m_irq = 1'b0;
  logic [1:0]  m_alarm_q = '0;

  task automatic model_step();
    logic [1:0] hv;
    if (!rst_n) begin
      mode = M_ARM; arm_elapsed = 0; win_valid = 1'b0; win_hits = 0;
      hit_total = 0; m_src = '0; m_irq = 1'b0; m_alarm_q = '0;
    end else begin
      hv    = m_alarm_q & en;
      m_irq = 1'b0;
      if (mode == M_ARM) begin
        arm_elapsed++;
        if (arm_elapsed >= ARM) mode = M_MON;
      end else if (mode == M_MON) begin
        if (hv != 0) begin
          hit_total++;
          if (win_valid && (t - win_start) < WIN) win_hits++;
          else begin
            win_valid = 1'b1; win_start = t; win_hits = 1;
          end
          if (win_hits >= THR) begin
            mode = M_FAULT; m_irq = 1'b1; m_src = hv; win_valid = 1'b0;
          end
        end
      end else begin
        if (hv != 0) hit_total++;
        if (clr) begin
          mode = M_ARM; arm_elapsed = 0;
        end
      end
      m_alarm_q = alarm;
    end
    t++;
  endtask

  task automatic step(input logic [1:0] a, input logic [1:0] e, input logic c, input logic r);
    exp_t x;
    @(negedge clk);
    alarm = a; en = e; clr = c; rst_n = r;
    model_step();
    x.armed = (mode == M_MON);
    x.fault = (mode == M_FAULT);
    x.irq   = m_irq;
    x.cnt_a = (hit_total > 65535) ? 65535 : hit_total;
    x.cnt_b = (hit_total > 15) ? 15 : hit_total;
    x.src   = m_src;
    sb_q.push_back(x);
    active = 1'b1;
  endtask

  task automatic idle(input int n, input logic [1:0] e);
    for (int i = 0; i < n; i++) step(2'b00, e, 1'b0, 1'b1);
  endtask

  task automatic chk(input string name, input int unsigned act, input int unsigned exp_v);
    if (act != exp_v) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp_v, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        n_vec++;
        chk("armed_o",     ifa.armed_o,     e.armed);
        chk("fault_o",     ifa.fault_o,     e.fault);
        chk("halt_o",      ifa.halt_o,      e.fault);
        chk("fault_irq_o", ifa.fault_irq_o, e.irq);
        chk("hit_cnt_o",   ifa.hit_cnt_o,   e.cnt_a);
        chk("first_src_o", ifa.first_src_o, e.src);
        chk("hit_cnt_o_w4", ifb.hit_cnt_o,  e.cnt_b);
        chk("fault_o_w4",  ifb.fault_o,     e.fault);
        chk("fault_irq_o_w4", ifb.fault_irq_o, e.irq);
        $display("cyc %0d: armed=%0b fault=%0b irq=%0b cnt=%0d cnt4=%0d src=%b",
                 n_vec, ifa.armed_o, ifa.fault_o, ifa.fault_irq_o, ifa.hit_cnt_o,
                 ifb.hit_cnt_o, ifa.first_src_o);
      end else if (active) begin
        n_miss++;
        $display("FAIL scoreboard: got empty queue expected pending entry at t=%0t", $time);
      end
    end
  end

  initial begin : driver
    logic [1:0] rnd_en;
    rst_n = 1'b0; alarm = '0; en = 2'b11; clr = 1'b0;
    for (int i = 0; i < 3; i++) step(2'b00, 2'b11, 1'b0, 1'b0);

    // Alarm held through arming, then faults once monitoring starts.
    for (int i = 0; i < 10; i++) step(2'b01, 2'b11, 1'b0, 1'b1);
    idle(6, 2'b11);
    step(2'b00, 2'b11, 1'b1, 1'b1);
    idle(12, 2'b11);

    // Two pulses 20 cycles apart: outside one window.
    step(2'b01, 2'b11, 1'b0, 1'b1);
    idle(19, 2'b11);
    step(2'b01, 2'b11, 1'b0, 1'b1);
    idle(20, 2'b11);

    // Sensor 1 pulses 5 apart -> fault, then clear and re-arm.
    step(2'b10, 2'b11, 1'b0, 1'b1);
    idle(4, 2'b11);
    step(2'b10, 2'b11, 1'b0, 1'b1);
    idle(5, 2'b11);
    step(2'b00, 2'b11, 1'b1, 1'b1);
    idle(12, 2'b11);

    // Masked sensor and clear while monitoring.
    step(2'b10, 2'b01, 1'b0, 1'b1);
    idle(1, 2'b01);
    step(2'b10, 2'b01, 1'b0, 1'b1);
    step(2'b00, 2'b01, 1'b1, 1'b1);
    idle(20, 2'b01);

    // Window edges: second hit on the last window cycle, then one past it.
    step(2'b01, 2'b11, 1'b0, 1'b1);
    idle(14, 2'b11);
    step(2'b01, 2'b11, 1'b0, 1'b1);
    idle(4, 2'b11);
    step(2'b00, 2'b11, 1'b1, 1'b1);
    idle(12, 2'b11);
    step(2'b01, 2'b11, 1'b0, 1'b1);
    idle(15, 2'b11);
    step(2'b01, 2'b11, 1'b0, 1'b1);
    idle(20, 2'b11);

    // Reset right after an in-window hit discards the window.
    step(2'b01, 2'b11, 1'b0, 1'b1);
    idle(1, 2'b11);
    step(2'b00, 2'b11, 1'b0, 1'b0);
    idle(10, 2'b11);
    step(2'b01, 2'b11, 1'b0, 1'b1);
    idle(20, 2'b11);

    // Long burst saturates the narrow counter; clear with a simultaneous hit.
    for (int i = 0; i < 25; i++) step(2'b11, 2'b11, 1'b0, 1'b1);
    step(2'b00, 2'b11, 1'b1, 1'b1);
    idle(12, 2'b11);

    // Randomized traffic.
    rnd_en = 2'b11;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 49) == 0) rnd_en = 2'($urandom_range(0, 3));
      step({($urandom_range(0, 11) == 0), ($urandom_range(0, 11) == 0)}, rnd_en,
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 299) != 0));
    end

    @(posedge clk);
    #2;
    active = 1'b0;
    if (sb_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: got %0d entries left expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
